// File: rtl/seven_seg_scan_if.sv
// Bus bundle for the multiplexed 7-segment scanner.
// master: drives disp_tick, enable, value, dp_en and blank_lz; observes the display outputs.
// slave : the scanner itself.
//   disp_tick  - divided display clock (level, synchronous to clk)
//   enable     - 1 = scan, 0 = all digits dark
//   value      - hex digits, nibble k drives digit k
//   dp_en      - decimal point request per digit
//   blank_lz   - 1 = suppress leading zeros
//   an         - anode enables, active low
//   seg        - segments {g,f,e,d,c,b,a}, active low
//   dp         - decimal point, active low
//   digit_idx  - digit currently selected
//   frame_done - one-cycle pulse when the scan wraps to digit 0
interface seven_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                    disp_tick;
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output disp_tick, enable, value, dp_en, blank_lz,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  disp_tick, enable, value, dp_en, blank_lz,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment display driver.
// Each rising edge of disp_tick (seen while a digit is driven) starts a blanking interval of
// BLANK_CYCLES clk cycles, after which the next digit is driven. The displayed value, decimal
// points and leading-zero mode are latched once per frame, on the switch to digit 0.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high reset
//   bus   - seven_seg_scan_if slave modport (tick/enable/value inputs, display outputs)
// All outputs are registered.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  seven_seg_scan_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic                    tick_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fd_q, fd_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_lz_q, sh_lz_d;

  logic                    rise;
  logic [IDX_W-1:0]        next_idx;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] src_value;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic                    src_lz;
  logic [3:0]              nibble;
  logic                    upper_zero;
  logic [6:0]              next_seg;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign rise = bus.disp_tick & ~tick_q;

  // Digit that will be driven when the current blanking interval ends. On a wrap the shadow
  // registers load on the same edge, so the new digit must be decoded from the live inputs.
  always_comb begin
    next_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    wrap       = (next_idx == '0);
    src_value  = wrap ? bus.value    : sh_value_q;
    src_dp     = wrap ? bus.dp_en    : sh_dp_q;
    src_lz     = wrap ? bus.blank_lz : sh_lz_q;
    nibble     = src_value[4*int'(next_idx) +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (j >= int'(next_idx)) begin
        if ((src_value[4*j +: 4] != 4'h0) || src_dp[j]) begin
          upper_zero = 1'b0;
        end
      end
    end
    // Digit 0 always shows, even when the whole value is zero.
    if (src_lz && (next_idx != '0) && upper_zero) begin
      next_seg = 7'h7F;
    end else begin
      next_seg = hex_to_seg(nibble);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    fd_d       = 1'b0;
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_lz_d    = sh_lz_q;

    if (!bus.enable) begin
      state_d = StIdle;
      idx_d   = LAST_IDX;
      an_d    = '1;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Parking on the last digit makes the first driven digit wrap to 0 with a fresh latch.
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = LAST_IDX;
          an_d    = '1;
          seg_d   = 7'h7F;
          dp_d    = 1'b1;
        end
        StBlank: begin
          if (cnt_q == CNT_LAST) begin
            state_d = StDrive;
            idx_d   = next_idx;
            an_d    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << next_idx);
            seg_d   = next_seg;
            dp_d    = ~src_dp[next_idx];
            if (wrap) begin
              sh_value_d = bus.value;
              sh_dp_d    = bus.dp_en;
              sh_lz_d    = bus.blank_lz;
              fd_d       = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StDrive: begin
          if (rise) begin
            state_d = StBlank;
            cnt_d   = '0;
            an_d    = '1;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
      sh_value_q <= '0;
      sh_dp_q    <= '0;
      sh_lz_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= bus.disp_tick;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
      sh_value_q <= sh_value_d;
      sh_dp_q    <= sh_dp_d;
      sh_lz_q    <= sh_lz_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;
  localparam int unsigned N  = 4;
  localparam int unsigned BC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS  (N),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scan position, remaining dark cycles and the per-frame latched display.
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  bit          m_on, m_prev, m_lz, m_rise;
  int          m_dark, m_digit;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  int          e_idx;

  function automatic logic [6:0] model_seg(input int d);
    logic [3:0] nib;
    nib = 4'(m_val >> (4 * d));
    if (d > 0 && m_lz && (m_val >> (4 * d)) == 0 && (m_dp >> d) == 0) return 7'h7F;
    return seg_tab[nib];
  endfunction

  task automatic model_dark();
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
  endtask

  always begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_on = 0; m_prev = 0; m_lz = 0; m_dark = 0; m_digit = 0; m_val = '0; m_dp = '0;
      model_dark();
      e_fd = 0;
    end else begin
      m_rise = bus.disp_tick && !m_prev;
      m_prev = bus.disp_tick;
      e_fd   = 0;
      if (!bus.enable) begin
        m_on = 0; m_digit = N - 1;
        model_dark();
      end else if (!m_on) begin
        m_on = 1; m_dark = BC; m_digit = N - 1;
        model_dark();
      end else if (m_dark > 0) begin
        m_dark--;
        if (m_dark == 0) begin
          m_digit = (m_digit + 1) % N;
          if (m_digit == 0) begin
            m_val = bus.value; m_dp = bus.dp_en; m_lz = bus.blank_lz;
            e_fd  = 1;
          end
          e_an  = 4'hF ^ (4'b1 << m_digit);
          e_seg = model_seg(m_digit);
          e_dp  = !m_dp[m_digit];
        end
      end else if (m_rise) begin
        m_dark = BC;
        model_dark();
      end
    end
    e_idx = m_digit;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an", 32'(bus.an), 32'(e_an));
      check("model_seg", 32'(bus.seg), 32'(e_seg));
      check("model_dp", 32'(bus.dp), 32'(e_dp));
      check("model_digit_idx", 32'(bus.digit_idx), 32'(e_idx));
      check("model_frame_done", 32'(bus.frame_done), 32'(e_fd));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick rise while driving, then wait until the next digit is driven.
  task automatic advance();
    bus.disp_tick = 1'b1;
    cyc(1);
    bus.disp_tick = 1'b0;
    cyc(BC);
  endtask

  task automatic pin(input string name, input logic [3:0] an, input logic [6:0] seg);
    check({name, "_an"}, 32'(bus.an), 32'(an));
    check({name, "_seg"}, 32'(bus.seg), 32'(seg));
  endtask

  initial begin
    reset         = 1'b1;
    bus.disp_tick = 1'b0;
    bus.enable    = 1'b0;
    bus.value     = 16'h12AF;
    bus.dp_en     = 4'b0000;
    bus.blank_lz  = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    check("reset_an", 32'(bus.an), 32'hF);
    check("reset_seg", 32'(bus.seg), 32'h7F);
    check("reset_dp", 32'(bus.dp), 32'h1);
    check("reset_idx", 32'(bus.digit_idx), 32'h0);
    check("reset_fd", 32'(bus.frame_done), 32'h0);

    // Release reset with the tick already high.
    bus.disp_tick = 1'b1;
    reset         = 1'b0;
    bus.enable    = 1'b1;
    cyc(4);
    check("first_blank_an", 32'(bus.an), 32'hF);
    cyc(1);
    pin("digit0_F", 4'b1110, 7'b0001110);
    check("first_fd", 32'(bus.frame_done), 32'h1);
    cyc(1);
    check("fd_single", 32'(bus.frame_done), 32'h0);
    cyc(10);
    check("held_tick_no_adv", 32'(bus.digit_idx), 32'h0);
    bus.disp_tick = 1'b0;
    cyc(1);
    advance(); pin("digit1_A", 4'b1101, 7'b0001000);
    advance(); pin("digit2_2", 4'b1011, 7'b0100100);
    advance(); pin("digit3_1", 4'b0111, 7'b1111001);
    advance(); pin("wrap_F", 4'b1110, 7'b0001110);
    check("wrap_fd", 32'(bus.frame_done), 32'h1);

    // Leading-zero blanking.
    bus.value    = 16'h0030;
    bus.blank_lz = 1'b1;
    advance(); pin("old_frame_d1", 4'b1101, 7'b0001000);
    advance(); advance(); advance();
    pin("lz_d0", 4'b1110, 7'b1000000);
    advance(); pin("lz_d1", 4'b1101, 7'b0110000);
    advance(); pin("lz_d2", 4'b1011, 7'h7F);
    advance(); pin("lz_d3", 4'b0111, 7'h7F);
    bus.dp_en = 4'b1000;
    advance(); pin("lzdp_d0", 4'b1110, 7'b1000000);
    check("lzdp_d0_dp", 32'(bus.dp), 32'h1);
    advance(); pin("lzdp_d1", 4'b1101, 7'b0110000);
    advance(); pin("lzdp_d2", 4'b1011, 7'b1000000);
    advance(); pin("lzdp_d3", 4'b0111, 7'b1000000);
    check("lzdp_d3_dp", 32'(bus.dp), 32'h0);

    // Mid-frame value change stays invisible until the wrap.
    bus.value    = 16'h1111;
    bus.blank_lz = 1'b0;
    bus.dp_en    = 4'b0000;
    advance(); advance(); advance();
    bus.value = 16'h2222;
    pin("tear_d2", 4'b1011, 7'b1111001);
    advance(); pin("tear_d3", 4'b0111, 7'b1111001);
    advance(); pin("tear_wrap", 4'b1110, 7'b0100100);
    check("tear_fd", 32'(bus.frame_done), 32'h1);

    // Disable while driving, then re-enable.
    advance();
    bus.enable = 1'b0;
    cyc(1);
    pin("disable", 4'hF, 7'h7F);
    check("disable_idx", 32'(bus.digit_idx), 32'h3);
    cyc(2);
    bus.enable = 1'b1;
    cyc(5);
    pin("reenable", 4'b1110, 7'b0100100);
    check("reenable_fd", 32'(bus.frame_done), 32'h1);

    // Asynchronous reset in the middle of a blanking interval.
    advance();
    bus.disp_tick = 1'b1;
    cyc(1);
    bus.disp_tick = 1'b0;
    cyc(1);
    #2 reset = 1'b1;
    #1;
    pin("async_reset", 4'hF, 7'h7F);
    check("async_reset_idx", 32'(bus.digit_idx), 32'h0);
    check("async_reset_fd", 32'(bus.frame_done), 32'h0);
    check("async_reset_dp", 32'(bus.dp), 32'h1);
    cyc(2);
    reset = 1'b0;
    cyc(8);
    check("post_reset_d0", 32'(bus.an), 32'b1110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
